// File: rtl/paicore_lb_pkg.sv
// Shared types and constants for the PAICORE loopback run controller.
package paicore_lb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_ARM,
    ST_TX,
    ST_RX,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_PROTO   = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  localparam int unsigned DEF_RST_CYCLES = 4;
  localparam int unsigned ITER_W         = 16;
  localparam int unsigned LEN_W          = 32;

endpackage

// File: rtl/paicore_lb_watchdog.sv
// Saturating per-state cycle counter; count reads 1 on the first cycle after clear.
module paicore_lb_watchdog #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired_c,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= CNT_W'(1);
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero limit disables expiry.
  assign expired_c = (limit != '0) && (count >= limit);

endmodule

// File: rtl/paicore_loopback_ctrl.sv
// Run controller for the PAICORE send/recv loopback: sequences reset/arm/tx/rx iterations,
// supervises each phase with a watchdog and reports cycle counts and run status.
module paicore_loopback_ctrl
  import paicore_lb_pkg::*;
#(
  parameter int unsigned Channel    = 2,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ITER_W-1:0]  repeat_cnt,
  input  logic [LEN_W-1:0]   send_len_in,
  input  logic [LEN_W-1:0]   frame_num_in,
  input  logic               single_chan_in,
  input  logic [Channel-1:0] chan_mask_in,
  input  logic [CNT_W-1:0]   timeout_cycles,
  input  logic               i_tx_done,
  input  logic               i_rx_done,
  output logic               o_dp_rst,
  output logic               o_rx_rcving,
  output logic [LEN_W-1:0]   o_send_len,
  output logic [LEN_W-1:0]   o_frame_num_max,
  output logic               o_single_chan,
  output logic [Channel-1:0] o_chan_mask,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [1:0]         o_err_code,
  output logic [ITER_W-1:0]  o_iter_cnt,
  output logic [CNT_W-1:0]   o_tx_cycles,
  output logic [CNT_W-1:0]   o_rx_cycles
);

  state_t             state, state_n;
  logic [ITER_W-1:0]  rep_max;
  logic [ITER_W-1:0]  iter_n, iter_inc;
  logic [CNT_W-1:0]   tx_n, rx_n;
  logic [1:0]         err_code_n;
  logic               err_n;
  logic               latch_cfg;
  logic               finish;
  logic               wd_exp;
  logic               wd_clear;
  logic               wd_en;
  logic               in_hold;
  logic [CNT_W-1:0]   wd_limit;
  logic [CNT_W-1:0]   wd_count;

  // One timer serves both the TX/RX watchdog and the CLR/ERR reset hold.
  assign in_hold  = (state == ST_CLR) || (state == ST_ERR);
  assign wd_en    = in_hold || (state == ST_TX) || (state == ST_RX);
  assign wd_clear = (state_n != state);
  assign wd_limit = in_hold ? CNT_W'(RST_CYCLES) : timeout_cycles;

  paicore_lb_watchdog #(
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .enable    (wd_en),
    .limit     (wd_limit),
    .expired_c (wd_exp),
    .count     (wd_count)
  );

  assign iter_inc = (o_iter_cnt == '1) ? o_iter_cnt : o_iter_cnt + ITER_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    err_code_n = o_err_code;
    err_n      = o_err;
    iter_n     = o_iter_cnt;
    tx_n       = o_tx_cycles;
    rx_n       = o_rx_cycles;
    latch_cfg  = 1'b0;
    finish     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_CLR;
          latch_cfg  = 1'b1;
          err_n      = 1'b0;
          err_code_n = ERR_NONE;
          iter_n     = '0;
        end
      end
      ST_CLR: begin
        if (wd_exp) state_n = ST_ARM;
      end
      ST_ARM: begin
        state_n = ST_TX;
      end
      ST_TX: begin
        tx_n = wd_count;
        // A done on the expiry cycle beats the timeout; timeout beats protocol error.
        if (i_tx_done) begin
          if (i_rx_done) begin
            rx_n   = '0;
            finish = 1'b1;
          end else begin
            state_n = ST_RX;
          end
        end else if (wd_exp) begin
          state_n    = ST_ERR;
          err_code_n = ERR_TIMEOUT;
        end else if (i_rx_done) begin
          state_n    = ST_ERR;
          err_code_n = ERR_PROTO;
        end
      end
      ST_RX: begin
        rx_n = wd_count;
        if (i_rx_done) begin
          finish = 1'b1;
        end else if (wd_exp) begin
          state_n    = ST_ERR;
          err_code_n = ERR_TIMEOUT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      ST_ERR: begin
        if (wd_exp) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (finish) begin
      iter_n  = iter_inc;
      state_n = (iter_inc == rep_max) ? ST_DONE : ST_CLR;
    end

    if (abort && (state != ST_IDLE) && (state != ST_ERR)) begin
      state_n    = ST_ERR;
      err_code_n = ERR_ABORT;
      iter_n     = o_iter_cnt;
    end

    if (state_n == ST_ERR) err_n = 1'b1;
  end

  // State and registered outputs; flag outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      o_dp_rst        <= 1'b1;
      o_rx_rcving     <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
      o_err_code      <= ERR_NONE;
      o_iter_cnt      <= '0;
      o_tx_cycles     <= '0;
      o_rx_cycles     <= '0;
      o_send_len      <= '0;
      o_frame_num_max <= '0;
      o_single_chan   <= 1'b0;
      o_chan_mask     <= '0;
      rep_max         <= '0;
    end else begin
      state       <= state_n;
      o_dp_rst    <= (state_n == ST_CLR) || (state_n == ST_ERR);
      o_rx_rcving <= (state_n == ST_ARM) || (state_n == ST_TX) || (state_n == ST_RX);
      o_busy      <= (state_n != ST_IDLE);
      o_done      <= (state_n == ST_DONE);
      o_err       <= err_n;
      o_err_code  <= err_code_n;
      o_iter_cnt  <= iter_n;
      o_tx_cycles <= tx_n;
      o_rx_cycles <= rx_n;
      if (latch_cfg) begin
        o_send_len      <= send_len_in;
        o_frame_num_max <= frame_num_in;
        o_single_chan   <= single_chan_in;
        o_chan_mask     <= chan_mask_in;
        rep_max         <= (repeat_cnt == '0) ? ITER_W'(1) : repeat_cnt;
      end
    end
  end

endmodule

// File: tb/tb_paicore_loopback_ctrl.sv
// Directed bench for paicore_loopback_ctrl: normal runs, errors, aborts and reset recovery.
module tb_paicore_loopback_ctrl;

  localparam int unsigned CH = 2;
  localparam int unsigned RC = 4;
  localparam int unsigned CW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [15:0]   repeat_cnt;
  logic [31:0]   send_len_in;
  logic [31:0]   frame_num_in;
  logic          single_chan_in;
  logic [CH-1:0] chan_mask_in;
  logic [CW-1:0] timeout_cycles;
  logic          i_tx_done;
  logic          i_rx_done;
  logic          o_dp_rst;
  logic          o_rx_rcving;
  logic [31:0]   o_send_len;
  logic [31:0]   o_frame_num_max;
  logic          o_single_chan;
  logic [CH-1:0] o_chan_mask;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [1:0]    o_err_code;
  logic [15:0]   o_iter_cnt;
  logic [CW-1:0] o_tx_cycles;
  logic [CW-1:0] o_rx_cycles;

  int checks = 0;
  int errors = 0;

  paicore_loopback_ctrl #(
    .Channel    (CH),
    .RST_CYCLES (RC),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .repeat_cnt      (repeat_cnt),
    .send_len_in     (send_len_in),
    .frame_num_in    (frame_num_in),
    .single_chan_in  (single_chan_in),
    .chan_mask_in    (chan_mask_in),
    .timeout_cycles  (timeout_cycles),
    .i_tx_done       (i_tx_done),
    .i_rx_done       (i_rx_done),
    .o_dp_rst        (o_dp_rst),
    .o_rx_rcving     (o_rx_rcving),
    .o_send_len      (o_send_len),
    .o_frame_num_max (o_frame_num_max),
    .o_single_chan   (o_single_chan),
    .o_chan_mask     (o_chan_mask),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_err_code      (o_err_code),
    .o_iter_cnt      (o_iter_cnt),
    .o_tx_cycles     (o_tx_cycles),
    .o_rx_cycles     (o_rx_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles with o_dp_rst high, leaving the bench on the first cycle after the hold.
  task automatic wait_rst_hold(output int len);
    len = 0;
    while (o_dp_rst === 1'b1 && len < 50) begin
      len++;
      step();
    end
  endtask

  task automatic start_run(input logic [15:0] rep, input logic [31:0] tmo);
    repeat_cnt     = rep;
    timeout_cycles = tmo;
    start          = 1'b1;
    step();
    start          = 1'b0;
  endtask

  task automatic run_iter(input int txd, input int rxd, input bit both);
    int len;
    wait_rst_hold(len);
    chk("clr_len", 32'(len), 32'(RC));
    chk("arm_rcving", 32'(o_rx_rcving), 32'd1);
    repeat (txd) step();
    i_tx_done = 1'b1;
    i_rx_done = both;
    step();
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
    chk("tx_cycles", o_tx_cycles, 32'(txd));
    if (both) begin
      chk("rx_skipped", o_rx_cycles, 32'd0);
    end else begin
      repeat (rxd - 1) step();
      i_rx_done = 1'b1;
      step();
      i_rx_done = 1'b0;
      chk("rx_cycles", o_rx_cycles, 32'(rxd));
    end
  endtask

  task automatic check_done(input int exp_iter);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_done === 1'b1) pulses++;
      step();
    end
    chk("done_pulses", 32'(pulses), 32'd1);
    chk("done_idle", 32'(o_busy), 32'd0);
    chk("done_iter", 32'(o_iter_cnt), 32'(exp_iter));
    chk("done_noerr", 32'(o_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int len;
    rst            = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    repeat_cnt     = '0;
    send_len_in    = '0;
    frame_num_in   = '0;
    single_chan_in = 1'b0;
    chan_mask_in   = '0;
    timeout_cycles = '0;
    i_tx_done      = 1'b0;
    i_rx_done      = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_dp_rst", 32'(o_dp_rst), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_iter", 32'(o_iter_cnt), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    rst = 1'b0;
    step();
    chk("rel_dp_rst", 32'(o_dp_rst), 32'd0);

    // Three iterations: tx 10 cycles after ARM, rx 5 cycles later; config latched at start
    send_len_in    = 32'h1234_5678;
    frame_num_in   = 32'd77;
    single_chan_in = 1'b1;
    chan_mask_in   = 2'b10;
    start_run(16'd3, 32'd0);
    chk("start_dp_rst", 32'(o_dp_rst), 32'd1);
    send_len_in    = 32'h0;
    chan_mask_in   = 2'b01;
    run_iter(10, 5, 1'b0);
    chk("iter1_cnt", 32'(o_iter_cnt), 32'd1);
    chk("cfg_send_len", o_send_len, 32'h1234_5678);
    chk("cfg_chan_mask", 32'(o_chan_mask), 32'd2);
    chk("cfg_frame_num", o_frame_num_max, 32'd77);
    chk("cfg_single", 32'(o_single_chan), 32'd1);
    run_iter(10, 5, 1'b0);
    run_iter(10, 5, 1'b0);
    check_done(3);

    // TX timeout at 20 cycles, reset held through ERR, back to IDLE
    start_run(16'd1, 32'd20);
    wait_rst_hold(len);
    repeat (20) step();
    chk("pre_timeout_err", 32'(o_err), 32'd0);
    step();
    chk("timeout_err", 32'(o_err), 32'd1);
    chk("timeout_code", 32'(o_err_code), 32'd1);
    chk("timeout_dp_rst", 32'(o_dp_rst), 32'd1);
    chk("timeout_rcving", 32'(o_rx_rcving), 32'd0);
    chk("timeout_tx_cycles", o_tx_cycles, 32'd20);
    wait_rst_hold(len);
    chk("err_hold_len", 32'(len), 32'(RC));
    chk("err_idle", 32'(o_busy), 32'd0);
    chk("err_sticky", 32'(o_err), 32'd1);

    // Simultaneous tx/rx done skips RX
    start_run(16'd1, 32'd0);
    chk("start_clears_err", 32'(o_err), 32'd0);
    run_iter(7, 0, 1'b1);
    check_done(1);

    // rx_done during TX is a protocol error; next start recovers
    start_run(16'd1, 32'd0);
    wait_rst_hold(len);
    repeat (3) step();
    i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    chk("proto_err", 32'(o_err), 32'd1);
    chk("proto_code", 32'(o_err_code), 32'd2);
    wait_rst_hold(len);
    chk("proto_idle", 32'(o_busy), 32'd0);
    start_run(16'd2, 32'd0);
    chk("restart_err", 32'(o_err), 32'd0);
    chk("restart_code", 32'(o_err_code), 32'd0);
    run_iter(2, 3, 1'b0);
    run_iter(5, 1, 1'b0);
    check_done(2);

    // Abort on the watchdog expiry cycle wins; start during ERR hold is ignored
    start_run(16'd1, 32'd20);
    wait_rst_hold(len);
    repeat (20) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_err", 32'(o_err), 32'd1);
    chk("abort_code", 32'(o_err_code), 32'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_start_busy", 32'(o_busy), 32'd1);
    wait_rst_hold(len);
    chk("abort_hold_rest", 32'(len), 32'(RC - 1));
    chk("abort_idle", 32'(o_busy), 32'd0);
    chk("abort_code_kept", 32'(o_err_code), 32'd3);

    // repeat_cnt of zero runs exactly one iteration
    start_run(16'd0, 32'd0);
    run_iter(4, 2, 1'b0);
    check_done(1);

    // Reset in the middle of RX
    start_run(16'd2, 32'd0);
    wait_rst_hold(len);
    repeat (5) step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    step();
    chk("mid_rx_rcving", 32'(o_rx_rcving), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_rcving", 32'(o_rx_rcving), 32'd0);
    chk("midrst_tx_cycles", o_tx_cycles, 32'd0);
    chk("midrst_dp_rst", 32'(o_dp_rst), 32'd1);
    chk("midrst_send_len", o_send_len, 32'd0);
    rst = 1'b0;
    step();
    chk("midrst_rel_dp_rst", 32'(o_dp_rst), 32'd0);
    chk("midrst_rel_busy", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
